// File: rtl/spi_flash_word_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | spi_flash_word_reader: SPI NOR 32-bit little-endian word reader, CS-low stream |
// | rev 1.0 - define FLASH_FAST_READ_EN for 0x0B fast read with 8 dummy clocks     |
// +--------------------------------------------------------------------------------+
module spi_flash_word_reader #(
  parameter int unsigned CLK_DIV         = 1,
  parameter logic [15:0] PWRUP_CYCLES    = 16'd1000,
  parameter logic [15:0] WAKE_GAP_CYCLES = 16'd600,
  parameter logic [7:0]  CS_HIGH_CYCLES  = 8'd4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [23:0] addr,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        spi_cs,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam logic [3:0] S_PWRUP   = 4'd0;
  localparam logic [3:0] S_WAKE    = 4'd1;
  localparam logic [3:0] S_CS_END  = 4'd2;
  localparam logic [3:0] S_CS_HIGH = 4'd3;
  localparam logic [3:0] S_IDLE    = 4'd4;
  localparam logic [3:0] S_CMD     = 4'd5;
  localparam logic [3:0] S_ADDR    = 4'd6;
  localparam logic [3:0] S_DATA    = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
`ifdef FLASH_FAST_READ_EN
  localparam logic [3:0] S_DUMMY   = 4'd7;
  localparam logic [7:0] READ_CMD  = 8'h0B;
`else
  localparam logic [7:0] READ_CMD  = 8'h03;
`endif
  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  logic [3:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bits_q, bits_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic [23:0] addr_q, addr_d;
  logic [23:0] next_addr_q, next_addr_d;
  logic        stream_q, stream_d;
  logic        hold_q, hold_d;

  logic        w_shifting;
  logic        w_bit_end;
  logic [23:0] w_word;

  assign w_word = addr & 24'hFFFFFC;

`ifdef FLASH_FAST_READ_EN
  assign w_shifting = (state_q == S_WAKE) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DUMMY) || (state_q == S_DATA);
`else
  assign w_shifting = (state_q == S_WAKE) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_DATA);
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    sclk_d      = sclk_q;
    cs_d        = cs_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    busy_d      = busy_q;
    addr_d      = addr_q;
    next_addr_d = next_addr_q;
    stream_d    = stream_q;
    hold_d      = 1'b0;
    w_bit_end   = 1'b0;

    // Shared bit engine: rising half samples miso, falling half shifts mosi and counts the bit.
    if (w_shifting) begin
      if (div_q != 8'd0) begin
        div_d = div_q - 8'd1;
      end else begin
        div_d  = DIV_RELOAD;
        sclk_d = ~sclk_q;
        if (!sclk_q) begin
          rx_d = {rx_q[30:0], spi_miso};
        end else begin
          tx_d      = {tx_q[30:0], 1'b0};
          bits_d    = bits_q - 6'd1;
          w_bit_end = (bits_q == 6'd1);
        end
      end
    end

    case (state_q)
      S_PWRUP: begin
        if (cnt_q + 16'd1 >= PWRUP_CYCLES) begin
          state_d = S_WAKE;
          cs_d    = 1'b0;
          tx_d    = {8'hAB, 24'h000000};
          bits_d  = 6'd8;
          div_d   = DIV_RELOAD;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAKE: begin
        if (w_bit_end) begin
          state_d = S_CS_END;
          cnt_d   = WAKE_GAP_CYCLES;
        end
      end
      S_CS_END: begin
        if (div_q == 8'd0) begin
          cs_d    = 1'b1;
          state_d = S_CS_HIGH;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_CS_HIGH: begin
        if (cnt_q > 16'd1) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_IDLE: begin
        // hold_q masks the cycle right after ready so the requester can update addr.
        if (!hold_q) begin
          if (stream_q && !(valid && (w_word == next_addr_q))) begin
            stream_d = 1'b0;
            state_d  = S_CS_END;
            div_d    = DIV_RELOAD;
            cnt_d    = {8'd0, CS_HIGH_CYCLES};
          end else if (stream_q) begin
            state_d = S_DATA;
            addr_d  = w_word;
            bits_d  = 6'd32;
            div_d   = DIV_RELOAD;
          end else if (valid) begin
            state_d = S_CMD;
            cs_d    = 1'b0;
            addr_d  = w_word;
            tx_d    = {READ_CMD, w_word};
            bits_d  = 6'd8;
            div_d   = DIV_RELOAD;
          end
        end
      end
      S_CMD: begin
        if (w_bit_end) begin
          state_d = S_ADDR;
          bits_d  = 6'd24;
        end
      end
      S_ADDR: begin
        if (w_bit_end) begin
`ifdef FLASH_FAST_READ_EN
          state_d = S_DUMMY;
          bits_d  = 6'd8;
`else
          state_d = S_DATA;
          bits_d  = 6'd32;
`endif
        end
      end
`ifdef FLASH_FAST_READ_EN
      S_DUMMY: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          bits_d  = 6'd32;
        end
      end
`endif
      S_DATA: begin
        if (w_bit_end) begin
          state_d = S_DONE;
          ready_d = 1'b1;
          rdata_d = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
        end
      end
      S_DONE: begin
        next_addr_d = addr_q + 24'd4;
        stream_d    = 1'b1;
        hold_d      = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_PWRUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PWRUP;
      cnt_q       <= 16'd0;
      div_q       <= 8'd0;
      bits_q      <= 6'd0;
      tx_q        <= 32'd0;
      rx_q        <= 32'd0;
      sclk_q      <= 1'b0;
      cs_q        <= 1'b1;
      ready_q     <= 1'b0;
      rdata_q     <= 32'd0;
      busy_q      <= 1'b1;
      addr_q      <= 24'd0;
      next_addr_q <= 24'd0;
      stream_q    <= 1'b0;
      hold_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      sclk_q      <= sclk_d;
      cs_q        <= cs_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      addr_q      <= addr_d;
      next_addr_q <= next_addr_d;
      stream_q    <= stream_d;
      hold_q      <= hold_d;
    end
  end

  assign ready    = ready_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign spi_cs   = cs_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = tx_q[31];

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_word_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------------+
// | tb_spi_flash_word_reader: scoreboard bench with a behavioural SPI NOR model    |
// | rev 1.0 - build with FLASH_FAST_READ_EN to run at CLK_DIV=3 with fast read     |
// +--------------------------------------------------------------------------------+
module tb_spi_flash_word_reader;

`ifdef FLASH_FAST_READ_EN
  localparam int         CLK_DIV = 3;
  localparam logic [7:0] RD_CMD  = 8'h0B;
  localparam int         DSTART  = 40;
`else
  localparam int         CLK_DIV = 1;
  localparam logic [7:0] RD_CMD  = 8'h03;
  localparam int         DSTART  = 32;
`endif
  localparam int WAKE_GAP = 600;
  localparam int CS_HIGH  = 4;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b1;
  logic        valid    = 1'b0;
  logic [23:0] addr     = 24'd0;
  logic        spi_miso = 1'b0;
  logic        ready;
  logic [31:0] rdata;
  logic        busy;
  logic        spi_cs;
  logic        spi_sclk;
  logic        spi_mosi;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] cmd_q[$];

  int          nbits       = 0;
  logic [7:0]  cmd_sh      = 8'd0;
  logic [23:0] fa_sh       = 24'd0;
  int          wake_cnt    = 0;
  int          rdcmd_cnt   = 0;
  int          cs_fall_cnt = 0;
  bit          last_wake   = 1'b0;
  int          cs_rise_cyc = 0;
  int          rise1_cyc   = 0;
  int          mdl_d;
  logic [7:0]  mdl_b;
  bit          ready_prev  = 1'b0;

  spi_flash_word_reader #(
    .CLK_DIV        (CLK_DIV),
    .PWRUP_CYCLES   (16'd1000),
    .WAKE_GAP_CYCLES(16'(WAKE_GAP)),
    .CS_HIGH_CYCLES (8'(CS_HIGH))
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .valid   (valid),
    .addr    (addr),
    .ready   (ready),
    .rdata   (rdata),
    .busy    (busy),
    .spi_cs  (spi_cs),
    .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, req);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h100000: return 8'h11;
      24'h100001: return 8'h22;
      24'h100002: return 8'h33;
      24'h100003: return 8'h44;
      24'h100004: return 8'h55;
      24'h100005: return 8'h66;
      24'h100006: return 8'h77;
      24'h100007: return 8'h88;
      24'h100008: return 8'h99;
      24'h100009: return 8'hAA;
      24'h10000A: return 8'hBB;
      24'h10000B: return 8'hCC;
      24'h140000: return 8'hDE;
      24'h140001: return 8'hAD;
      24'h140002: return 8'hBE;
      24'h140003: return 8'hEF;
      24'hFFFFFC: return 8'hA1;
      24'hFFFFFD: return 8'hB2;
      24'hFFFFFE: return 8'hC3;
      24'hFFFFFF: return 8'hD4;
      24'h000000: return 8'h01;
      24'h000001: return 8'h02;
      24'h000002: return 8'h03;
      24'h000003: return 8'h04;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Flash model: decodes command/address, streams bytes from the latched address while CS low.
  always @(posedge spi_sclk or posedge spi_cs) begin
    if (spi_cs) begin
      nbits    = 0;
      spi_miso = 1'b0;
    end else begin
      nbits++;
      if (nbits == 1) rise1_cyc = cyc;
      if (nbits == 2) check("sclk_period", 32'(cyc - rise1_cyc), 32'(2 * CLK_DIV));
      if (nbits <= 8) cmd_sh = {cmd_sh[6:0], spi_mosi};
      else if (nbits <= 32) fa_sh = {fa_sh[22:0], spi_mosi};
      if (nbits == 8) begin
        last_wake = (cmd_sh == 8'hAB);
        if (cmd_sh == 8'hAB) wake_cnt++;
        if (cmd_sh == RD_CMD) rdcmd_cnt++;
      end
      if (nbits == 32 && cmd_sh == RD_CMD) begin
        if (cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected: got %02h %06h with none pending", cmd_sh, fa_sh);
        end else begin
          check("cmd_addr", {cmd_sh, fa_sh}, cmd_q.pop_front());
        end
      end
      if (nbits >= DSTART && cmd_sh == RD_CMD) begin
        mdl_d    = nbits - DSTART;
        mdl_b    = mem_byte(fa_sh + 24'(mdl_d / 8));
        spi_miso = mdl_b[7 - (mdl_d % 8)];
      end
    end
  end

  always @(posedge spi_cs) cs_rise_cyc = cyc;

  always @(negedge spi_cs) begin
    cs_fall_cnt++;
    if (reset_n === 1'b1)
      check(last_wake ? "cs_gap_wake" : "cs_gap",
            32'((cyc - cs_rise_cyc) >= (last_wake ? WAKE_GAP : CS_HIGH)), 32'd1);
  end

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (ready_prev) check("ready_width", {31'd0, ready}, 32'd0);
      if (ready === 1'b1) begin
        check("busy_at_ready", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: got rdata %08h with no request pending", rdata);
        end else begin
          check("rdata", rdata, exp_q.pop_front());
        end
      end
    end
    ready_prev = (reset_n === 1'b1) && (ready === 1'b1);
  end

  task automatic serve(input logic [23:0] a, input bit last);
    int n;
    n     = 0;
    valid = 1'b1;
    addr  = a;
    do begin
      @(negedge clock);
      n++;
    end while (ready !== 1'b1 && n < 2000 * CLK_DIV);
    if (ready !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: got no ready for addr %06h, want ready within %0d clocks",
               a, 2000 * CLK_DIV);
    end
    @(posedge clock);
    #1;
    if (last) valid = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    int f0;
    int r0;
    int n;

    #2 reset_n = 1'b0;
    #20;
    check("rst_cs",    {31'd0, spi_cs},   32'd1);
    check("rst_sclk",  {31'd0, spi_sclk}, 32'd0);
    check("rst_mosi",  {31'd0, spi_mosi}, 32'd0);
    check("rst_ready", {31'd0, ready},    32'd0);
    check("rst_rdata", rdata,             32'd0);
    check("rst_busy",  {31'd0, busy},     32'd1);

    @(negedge clock) reset_n = 1'b1;
    wait_not_busy();
    check("pwrup_busy", {31'd0, busy}, 32'd0);
    check("wake_count", 32'(wake_cnt), 32'd1);

    // Cold read
    cmd_q.push_back({RD_CMD, 24'h100000});
    exp_q.push_back(32'h44332211);
    serve(24'h100000, 1'b1);
    repeat (20 * CLK_DIV) @(negedge clock);

    // Streaming three sequential words
    f0 = cs_fall_cnt;
    r0 = rdcmd_cnt;
    cmd_q.push_back({RD_CMD, 24'h100000});
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'h88776655);
    exp_q.push_back(32'hCCBBAA99);
    serve(24'h100000, 1'b0);
    serve(24'h100004, 1'b0);
    serve(24'h100008, 1'b1);
    repeat (20 * CLK_DIV) @(negedge clock);
    check("stream_cs_windows", 32'(cs_fall_cnt - f0), 32'd1);
    check("stream_cmds",       32'(rdcmd_cnt - r0),   32'd1);

    // Streaming across the 24-bit address wrap
    cmd_q.push_back({RD_CMD, 24'hFFFFFC});
    exp_q.push_back(32'hD4C3B2A1);
    exp_q.push_back(32'h04030201);
    serve(24'hFFFFFC, 1'b0);
    serve(24'h000000, 1'b1);
    repeat (20 * CLK_DIV) @(negedge clock);

    // Non-sequential jump forces a new command
    cmd_q.push_back({RD_CMD, 24'h100000});
    cmd_q.push_back({RD_CMD, 24'h140000});
    exp_q.push_back(32'h44332211);
    exp_q.push_back(32'hEFBEADDE);
    serve(24'h100000, 1'b0);
    serve(24'h140000, 1'b1);
    repeat (20 * CLK_DIV) @(negedge clock);

    // Asynchronous reset in the middle of the data phase
    cmd_q.push_back({RD_CMD, 24'h100004});
    valid = 1'b1;
    addr  = 24'h100004;
    n     = 0;
    while (nbits < DSTART + 13 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    check("reached_data", 32'(nbits >= DSTART + 13), 32'd1);
    #3 reset_n = 1'b0;
    #1;
    check("arst_cs",    {31'd0, spi_cs},   32'd1);
    check("arst_sclk",  {31'd0, spi_sclk}, 32'd0);
    check("arst_ready", {31'd0, ready},    32'd0);
    check("arst_rdata", rdata,             32'd0);
    check("arst_busy",  {31'd0, busy},     32'd1);
    valid = 1'b0;
    @(negedge clock) reset_n = 1'b1;
    wait_not_busy();
    check("rewake_busy",  {31'd0, busy},   32'd0);
    check("rewake_count", 32'(wake_cnt),   32'd2);

    cmd_q.push_back({RD_CMD, 24'h100008});
    exp_q.push_back(32'hCCBBAA99);
    serve(24'h100008, 1'b1);
    repeat (20 * CLK_DIV) @(negedge clock);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("cmd_q_drained", 32'(cmd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_flash_word_reader.md
Name: spi_flash_word_reader

Overview:
- SPI-flash front end feeding the cartridge loader. Accepts a 24-bit byte-address word request, fetches 4 bytes from SPI NOR flash (read 0x03), and returns them as one 32-bit little-endian word with a one-cycle ready pulse.
- Keeps CS low across sequential requests so a whole-cartridge load streams without re-issuing command/address.
- Wakes the flash from deep power-down (0xAB) after reset.

Parameters:
- CLK_DIV, 1, system clocks per SCK half-period (1..255); SCK = clock / (2*CLK_DIV).
- PWRUP_CYCLES, 16'd1000, clocks to wait after reset before the wake command.
- WAKE_GAP_CYCLES, 16'd600, clocks CS held high after 0xAB before the first read (tRES1).
- CS_HIGH_CYCLES, 8'd4, minimum clocks CS stays high between transactions.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- valid  in  1  word request, held high by requester until served
- addr  in  24  byte address of word; addr[1:0] ignored, treated as 0
- ready  out  1  one-cycle pulse: rdata valid, request done
- rdata  out  32  fetched word; first flash byte in [7:0], fourth in [31:24]
- busy  out  1  high from reset until the first IDLE entry
- spi_cs  out  1  flash chip select, active low
- spi_sclk  out  1  SPI clock, mode 0, idles low
- spi_mosi  out  1  serial data to flash, MSB first
- spi_miso  in  1  serial data from flash

Behaviour:
- Reset (async, reset_n=0): spi_cs=1, spi_sclk=0, spi_mosi=0, ready=0, rdata=0, busy=1, state=PWRUP, next_addr=0, streaming flag clear. Deassertion mid-transfer abandons it; nothing is replayed.
- SPI timing: mode 0. mosi changes while sclk low. miso sampled on the sclk rising-edge clock. Each bit = 2*CLK_DIV clocks. CS falls ≥CLK_DIV clocks before the first rising edge. CS rises ≥CLK_DIV clocks after the last falling edge.
- States:
  - PWRUP: count PWRUP_CYCLES, then -> WAKE.
  - WAKE: shift 0xAB with CS low, then CS high -> WAKE_GAP.
  - WAKE_GAP: count WAKE_GAP_CYCLES, busy<=0 -> IDLE.
  - IDLE: on valid:
    - streaming && {addr[23:2],2'b00}==next_addr -> DATA; CS stays low, no command issued.
    - streaming with address mismatch -> CS high for CS_HIGH_CYCLES -> CMD.
    - not streaming -> CMD.
    - valid low for ≥1 clock while streaming -> raise CS, clear streaming, hold CS high CS_HIGH_CYCLES before any new CMD.
  - CMD: shift 0x03 -> ADDR.
  - ADDR: shift {addr[23:2],2'b00}, 24 bits, MSB first -> DATA.
  - DATA: 32 rising-edge samples. Bytes assembled MSB-first per byte; byte k goes to rdata[8k+7:8k] -> DONE.
  - DONE: rdata updated, ready=1 for exactly one clock; next_addr <= word addr+4 (24-bit wrap 0xFFFFFC -> 0x000000); streaming set -> IDLE.
- Addr latching: addr is latched on CMD entry. Requester may change addr in the cycle after ready; IDLE ignores valid in the cycle immediately following DONE. Minimum one idle clock between ready pulses.
- Latency, CLK_DIV=1:
  - Cold read: ready 2+2*64+1 clocks after valid seen in IDLE (CS setup + 64 bits).
  - Streamed read: 64 sclk-phase clocks +2.
- rdata holds its value between ready pulses. ready never asserts while busy=1; valid during busy is held off, not lost.
- spi_sclk stays low whenever CS is high.

Optional Feature:
- FLASH_FAST_READ_EN defined:
  - CMD sends 0x0B instead of 0x03.
  - A DUMMY state of 8 sclk cycles (mosi=0) sits between ADDR and DATA.
  - Cold latency grows by 16*CLK_DIV clocks.
  - Streaming unchanged.
- FLASH_FAST_READ_EN undefined: DUMMY state absent, 0x03 used.

Test Plan:
- Power-up: release reset_n, model counts edges -> 0xAB seen exactly once, CS high ≥600 clocks after it, busy falls, no ready before.
- Cold read: valid, addr=0x100000, flash bytes 11 22 33 44 -> command 03 10 00 00, ready one cycle, rdata=0x44332211.
- Streaming: 3 requests at 0x100000, 0x100004, 0x100008 with valid held -> single CS-low window, one command, three ready pulses, rdata per word correct.
- Non-sequential: after 0x100000, request 0x140000 -> CS high ≥4 clocks, new 03 14 00 00 command issued.
- Async reset mid-DATA (after 13 bits): reset_n low -> spi_cs=1, sclk=0, ready=0, rdata=0 immediately, without a clock edge; after release the PWRUP/WAKE sequence repeats.
- CLK_DIV=3 with FLASH_FAST_READ_EN: sclk period 6 clocks; 0x0B plus 8 dummy cycles precede data; rdata correct.
